// File: rtl/mux_tree_ccff_cfg_pkg.sv
// Shared types and helpers for the configurable mux tree with its serial config chain.
package mux_tree_ccff_cfg_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Reset value of every bit in the shadow and active select words.
  localparam logic CfgRstBit = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StShifting,
    StArmed,
    StOver
  } cfg_state_e;

endpackage

// File: rtl/mux_tree_ccff_cfg_if.sv
// Config-chain and datapath signals of one mux tree instance.
interface mux_tree_ccff_cfg_if #(
  parameter int unsigned NUM_INPUTS = 8
) ();
  logic                  ccff_shift;
  logic                  ccff_head;
  logic                  ccff_tail;
  logic                  cfg_commit;
  logic [NUM_INPUTS-1:0] mux_in;
  logic                  mux_out;
  logic                  cfg_armed;
  logic                  cfg_err;

  modport master (
    output ccff_shift, ccff_head, cfg_commit, mux_in,
    input  ccff_tail, mux_out, cfg_armed, cfg_err
  );

  modport slave (
    input  ccff_shift, ccff_head, cfg_commit, mux_in,
    output ccff_tail, mux_out, cfg_armed, cfg_err
  );
endinterface

// File: rtl/mux_tree_cfg_level.sv
// One level of 2:1 basis cells; sel_i picks the even (lower) input, sel_n_i the odd one.
module mux_tree_cfg_level #(
  parameter int unsigned NumInputs = 2
) (
  input  logic [NumInputs-1:0]   in_i,
  input  logic                   sel_i,
  input  logic                   sel_n_i,
  output logic [NumInputs/2-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int unsigned j = 0; j < NumInputs / 2; j++) begin
      out_o[j] = (in_i[2*j] & sel_i) | (in_i[2*j+1] & sel_n_i);
    end
  end

endmodule

// File: rtl/mux_tree_ccff_cfg.sv
// N-input mux tree whose select word is loaded serially into a shadow register and
// committed atomically only after exactly SEL_BITS bits have been shifted in.
module mux_tree_ccff_cfg
  import mux_tree_ccff_cfg_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 8,
  parameter bit          REG_OUT    = 1'b0
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  mux_tree_ccff_cfg_if.slave   bus
);

  localparam int unsigned SEL_BITS  = clog2(NUM_INPUTS);
  localparam int unsigned CntW      = clog2(SEL_BITS + 1) + 1;
  localparam int unsigned LeafCount = 1 << SEL_BITS;
  localparam logic [CntW-1:0] CntArm = CntW'(SEL_BITS);
  localparam logic [CntW-1:0] CntSat = CntW'(SEL_BITS + 1);

  logic [SEL_BITS-1:0] shadow_q, shadow_d;
  logic [SEL_BITS-1:0] active_q, active_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  cfg_state_e          state_q, state_d;
  logic                err_q, err_d;
  logic                armed_q;
  logic                accept;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    err_d    = err_q;
    accept   = bus.cfg_commit && !bus.ccff_shift && (state_q == StArmed);
    if (accept) begin
      active_d = shadow_q;
      cnt_d    = '0;
      state_d  = StIdle;
    end else begin
      if (bus.cfg_commit) err_d = 1'b1;
      if (bus.ccff_shift) begin
        shadow_d = SEL_BITS'({shadow_q, bus.ccff_head});
        if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
        // Saturating count keeps an over-long load parked in StOver until reset.
        if (cnt_d == '0)         state_d = StIdle;
        else if (cnt_d < CntArm) state_d = StShifting;
        else if (cnt_d == CntArm) state_d = StArmed;
        else                     state_d = StOver;
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow_q <= {SEL_BITS{CfgRstBit}};
      active_q <= {SEL_BITS{CfgRstBit}};
      cnt_q    <= '0;
      state_q  <= StIdle;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      err_q    <= err_d;
      armed_q  <= (state_d == StArmed);
    end
  end

  assign bus.ccff_tail = shadow_q[SEL_BITS-1];
  assign bus.cfg_armed = armed_q;
  assign bus.cfg_err   = err_q;

  // Heap-ordered tree: node i has children 2i and 2i+1, leaves at LeafCount.., root at 1.
  logic [2*LeafCount-1:1] node;

  assign node[LeafCount +: NUM_INPUTS] = bus.mux_in;
  if (NUM_INPUTS < LeafCount) begin : g_pad
    assign node[2*LeafCount-1:LeafCount+NUM_INPUTS] = '0;
  end

  for (genvar k = 0; k < SEL_BITS; k++) begin : g_lvl
    localparam int unsigned NIn = LeafCount >> k;
    mux_tree_cfg_level #(
      .NumInputs(NIn)
    ) u_level (
      .in_i   (node[2*NIn-1:NIn]),
      .sel_i  (active_q[k]),
      .sel_n_i(~active_q[k]),
      .out_o  (node[NIn-1:NIn/2])
    );
  end

  if (REG_OUT) begin : g_reg_out
    logic out_q;
    always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) out_q <= 1'b0;
      else        out_q <= node[1];
    end
    assign bus.mux_out = out_q;
  end else begin : g_comb_out
    assign bus.mux_out = node[1];
  end

endmodule

// File: tb/tb_mux_tree_ccff_cfg.sv
// Directed bench: three instances (8 comb, 8 registered, 6 comb) share one config stream.
module tb_mux_tree_ccff_cfg;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mux_tree_ccff_cfg_if #(.NUM_INPUTS(8)) if8  ();
  mux_tree_ccff_cfg_if #(.NUM_INPUTS(8)) if8r ();
  mux_tree_ccff_cfg_if #(.NUM_INPUTS(6)) if6  ();

  mux_tree_ccff_cfg #(.NUM_INPUTS(8), .REG_OUT(1'b0)) u_dut8 (
    .prog_clk(clk), .pReset(rst), .bus(if8)
  );
  mux_tree_ccff_cfg #(.NUM_INPUTS(8), .REG_OUT(1'b1)) u_dut8r (
    .prog_clk(clk), .pReset(rst), .bus(if8r)
  );
  mux_tree_ccff_cfg #(.NUM_INPUTS(6), .REG_OUT(1'b0)) u_dut6 (
    .prog_clk(clk), .pReset(rst), .bus(if6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic sh, input logic hd, input logic cm);
    if8.ccff_shift  = sh; if8.ccff_head  = hd; if8.cfg_commit  = cm;
    if8r.ccff_shift = sh; if8r.ccff_head = hd; if8r.cfg_commit = cm;
    if6.ccff_shift  = sh; if6.ccff_head  = hd; if6.cfg_commit  = cm;
  endtask

  task automatic cyc(input logic sh, input logic hd, input logic cm);
    drive(sh, hd, cm);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_in(input logic [7:0] v8, input logic [5:0] v6);
    if8.mux_in  = v8;
    if8r.mux_in = v8;
    if6.mux_in  = v6;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    set_in(8'h80, 6'h3F);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state: active=000 selects index 7.
    chk("rst_out8",   if8.mux_out,   8'd1);
    chk("rst_armed",  if8.cfg_armed, 8'd0);
    chk("rst_err",    if8.cfg_err,   8'd0);
    chk("rst_tail",   if8.ccff_tail, 8'd0);
    chk("rst_out8r",  if8r.mux_out,  8'd0);
    chk("rst_out6",   if6.mux_out,   8'd0);
    set_in(8'h7F, 6'h00);
    chk("idx7_low",   if8.mux_out,   8'd0);
    set_in(8'h80, 6'h00);
    cyc(1'b0, 1'b0, 1'b0);
    chk("out8r_reg",  if8r.mux_out,  8'd1);

    // Full load 1,1,0 -> shadow 110 -> index 001.
    cyc(1'b1, 1'b1, 1'b0);
    chk("armed_1bit", if8.cfg_armed, 8'd0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("armed_3bit", if8.cfg_armed, 8'd1);
    chk("tail_3bit",  if8.ccff_tail, 8'd1);
    set_in(8'h02, 6'h02);
    cyc(1'b0, 1'b0, 1'b1);
    chk("commit_out8",     if8.mux_out,   8'd1);
    chk("commit_out8r_old", if8r.mux_out, 8'd0);
    chk("commit_out6",     if6.mux_out,   8'd1);
    chk("commit_armed",    if8.cfg_armed, 8'd0);
    chk("commit_err",      if8.cfg_err,   8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("commit_out8r_new", if8r.mux_out, 8'd1);

    // Partial load (2 bits) then commit: rejected, select unchanged.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("partial_err",   if8.cfg_err,   8'd1);
    chk("partial_armed", if8.cfg_armed, 8'd0);
    chk("partial_keep",  if8.mux_out,   8'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("third_armed",   if8.cfg_armed, 8'd1);
    // Shadow 010 -> index 101.
    cyc(1'b0, 1'b0, 1'b1);
    set_in(8'h20, 6'h20);
    chk("idx5_out8_hi",  if8.mux_out,   8'd1);
    chk("idx5_out6_hi",  if6.mux_out,   8'd1);
    set_in(8'hDF, 6'h1F);
    chk("idx5_out8_lo",  if8.mux_out,   8'd0);
    chk("idx5_out6_lo",  if6.mux_out,   8'd0);
    chk("err_sticky",    if8.cfg_err,   8'd1);

    // Asynchronous reset in the middle of a load.
    set_in(8'h20, 6'h20);
    cyc(1'b1, 1'b1, 1'b0);
    chk("pre_rst_tail",  if8.ccff_tail, 8'd1);
    chk("pre_rst_out8r", if8r.mux_out,  8'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tail",     if8.ccff_tail, 8'd0);
    chk("arst_err",      if8.cfg_err,   8'd0);
    chk("arst_armed",    if8.cfg_armed, 8'd0);
    chk("arst_out8r",    if8r.mux_out,  8'd0);
    chk("arst_out8_lo",  if8.mux_out,   8'd0);
    set_in(8'h80, 6'h00);
    chk("arst_out8_hi",  if8.mux_out,   8'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Over-long load: 4 shifts reach OVER, commit refused.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("over_armed3",   if8.cfg_armed, 8'd1);
    chk("over_tail3",    if8.ccff_tail, 8'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("over_armed4",   if8.cfg_armed, 8'd0);
    chk("over_tail4",    if8.ccff_tail, 8'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("over_err",      if8.cfg_err,   8'd1);
    chk("over_keep_hi",  if8.mux_out,   8'd1);
    set_in(8'h7F, 6'h00);
    chk("over_keep_lo",  if8.mux_out,   8'd0);

    // Commit together with shift while ARMED: shift wins, commit flagged.
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(8'h80, 6'h00);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("cs_armed_pre",  if8.cfg_armed, 8'd1);
    chk("cs_err_pre",    if8.cfg_err,   8'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("cs_err",        if8.cfg_err,   8'd1);
    chk("cs_armed",      if8.cfg_armed, 8'd0);
    chk("cs_keep_hi",    if8.mux_out,   8'd1);
    set_in(8'h02, 6'h00);
    chk("cs_keep_lo",    if8.mux_out,   8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
